// File: rtl/pixel_buf_pkg.sv
// Shared types and constants for the ping-pong pixel frame buffer.
package pixel_buf_pkg;

    localparam int unsigned DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_DONE = 2'd2
    } wr_state_e;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/pixel_pingpong_buf_if.sv
// Capture/display/status signals of pixel_pingpong_buf.
// drop_cnt exists only when PIXEL_BUF_DROP_CNT_EN is defined.
interface pixel_pingpong_buf_if #(
    parameter int unsigned DATA_W = 8
);
    import pixel_buf_pkg::*;

    logic              pi_flag;
    logic [DATA_W-1:0] rgb;
    logic              area2;
    logic              rd_en;
    logic              area;
    logic              clr_err;
    logic [DATA_W-1:0] dout;
    logic              dout_vld;
    logic              frame_rdy;
    logic              ovf;
    logic              udf;
`ifdef PIXEL_BUF_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt;
`endif

    modport master (
        output pi_flag, rgb, area2, rd_en, area, clr_err,
`ifdef PIXEL_BUF_DROP_CNT_EN
        input  drop_cnt,
`endif
        input  dout, dout_vld, frame_rdy, ovf, udf
    );

    modport slave (
        input  pi_flag, rgb, area2, rd_en, area, clr_err,
`ifdef PIXEL_BUF_DROP_CNT_EN
        output drop_cnt,
`endif
        output dout, dout_vld, frame_rdy, ovf, udf
    );

endinterface

// File: rtl/pixel_buf_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, array not reset.
module pixel_buf_dpram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AW     = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/pixel_pingpong_buf.sv
// Ping-pong pixel frame buffer: capture fills one bank, display reads the other.
// Optional PIXEL_BUF_DROP_CNT_EN adds a saturating count of ignored write strobes.
module pixel_pingpong_buf
    import pixel_buf_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       DEPTH     = 1024,
    parameter logic [DATA_W-1:0] BLANK_VAL = '0
) (
    input  logic                 sclk,
    input  logic                 rst_n,
    pixel_pingpong_buf_if.slave  bus
);

    localparam int unsigned       ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

    logic              area2_q, area_q;
    logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic              has_frame_q, has_frame_d;
    logic              frame_rdy_q, frame_rdy_d;
    logic              ovf_q, udf_q, dout_vld_q, blank_q, seen_q;
    wr_state_e         wst_q, wst_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic              area2_rise, area_rise, swap;
    logic              we, re, drop, ovf_set, udf_set;
    logic [ADDR_W:0]   waddr, raddr;
    logic [DATA_W-1:0] ram_rdata;

    // Swap is resolved first so a same-cycle area2 rise starts filling the new bank.
    always_comb begin
        area2_rise  = bus.area2 & ~area2_q;
        area_rise   = bus.area & ~area_q;
        swap        = area_rise & frame_rdy_q;
        wr_bank_d   = wr_bank_q ^ swap;
        rd_bank_d   = rd_bank_q ^ swap;
        has_frame_d = has_frame_q | swap;
        frame_rdy_d = frame_rdy_q & ~swap;
        udf_set     = area_rise & ~frame_rdy_q & ~has_frame_q;
        wst_d       = swap ? W_IDLE : wst_q;
        wr_addr_d   = wr_addr_q;
        we          = 1'b0;
        drop        = 1'b0;
        ovf_set     = 1'b0;
        if (wst_d != W_DONE && area2_rise) begin
            wst_d     = W_FILL;
            wr_addr_d = '0;
        end
        waddr = {wr_bank_d, wr_addr_d};
        case (wst_d)
            W_FILL: begin
                if (!bus.area2) begin
                    wst_d = W_IDLE;
                end else if (bus.pi_flag) begin
                    we = 1'b1;
                    if (wr_addr_d == LAST) begin
                        wst_d       = W_DONE;
                        frame_rdy_d = 1'b1;
                    end else begin
                        wr_addr_d = wr_addr_d + ADDR_W'(1);
                    end
                end
            end
            W_DONE: begin
                drop    = bus.pi_flag;
                ovf_set = bus.pi_flag & bus.area2;
            end
            default: drop = bus.pi_flag;
        endcase

        rd_addr_d = area_rise ? '0 : rd_addr_q;
        re        = bus.rd_en & bus.area;
        raddr     = {rd_bank_d, rd_addr_d};
        if (re) rd_addr_d = (rd_addr_d == LAST) ? '0 : rd_addr_d + ADDR_W'(1);
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            area2_q     <= 1'b0;
            area_q      <= 1'b0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b1;
            has_frame_q <= 1'b0;
            frame_rdy_q <= 1'b0;
            wst_q       <= W_IDLE;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            dout_vld_q  <= 1'b0;
            blank_q     <= 1'b1;
            seen_q      <= 1'b0;
        end else begin
            area2_q     <= bus.area2;
            area_q      <= bus.area;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            has_frame_q <= has_frame_d;
            frame_rdy_q <= frame_rdy_d;
            wst_q       <= wst_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            ovf_q       <= ovf_set | (ovf_q & ~bus.clr_err);
            udf_q       <= udf_set | (udf_q & ~bus.clr_err);
            dout_vld_q  <= re;
            if (re) begin
                blank_q <= ~has_frame_d;
                seen_q  <= 1'b1;
            end
        end
    end

    pixel_buf_dpram #(
        .DATA_W (DATA_W),
        .AW     (ADDR_W + 1)
    ) u_ram (
        .clk   (sclk),
        .we    (we),
        .waddr (waddr),
        .wdata (bus.rgb),
        .re    (re),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    // seen_q keeps dout at zero after reset until the first read lands.
    assign bus.dout      = !seen_q ? '0 : (blank_q ? BLANK_VAL : ram_rdata);
    assign bus.dout_vld  = dout_vld_q;
    assign bus.frame_rdy = frame_rdy_q;
    assign bus.ovf       = ovf_q;
    assign bus.udf       = udf_q;

`ifdef PIXEL_BUF_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop)             drop_cnt_d = bus.clr_err ? DROP_CNT_W'(1) : sat_inc(drop_cnt_q);
        else if (bus.clr_err) drop_cnt_d = '0;
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign bus.drop_cnt = drop_cnt_q;
`else
    logic drop_unused;
    assign drop_unused = drop;
`endif

endmodule

// File: tb/tb_pixel_pingpong_buf.sv
// Scoreboard bench for pixel_pingpong_buf at DEPTH=16, DATA_W=8, BLANK_VAL=0.
module tb_pixel_pingpong_buf;

    localparam int unsigned DEPTH = 16;

    logic sclk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    pixel_pingpong_buf_if #(.DATA_W(8)) bus ();

    pixel_pingpong_buf #(
        .DATA_W    (8),
        .DEPTH     (DEPTH),
        .BLANK_VAL (8'h00)
    ) dut (
        .sclk  (sclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    logic [7:0] exp_q [$];
    int         cyc_q [$];

    logic [7:0] m_wr [DEPTH];
    logic [7:0] m_rd [DEPTH];
    bit         m_rdy, m_has;
    int         m_rdaddr;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    always @(negedge sclk) begin
        if (rst_n && bus.dout_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("vld_unexpected", 1, 0);
            end else begin
                logic [7:0] d;
                int         c;
                d = exp_q.pop_front();
                c = cyc_q.pop_front();
                check("dout", bus.dout, d);
                check("latency", cyc, c);
            end
        end
    end

    task automatic write_frame(input int n, input logic [7:0] base);
        bus.area2 = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.pi_flag = 1'b1;
            bus.rgb     = base + 8'(i);
            if (i < DEPTH) m_wr[i] = base + 8'(i);
            if (i == DEPTH - 1) begin
                check("frame_rdy_before_last", bus.frame_rdy, 0);
                m_rdy = 1'b1;
            end
            tick();
        end
        bus.pi_flag = 1'b0;
    endtask

    task automatic area_rise();
        bus.area = 1'b1;
        m_rdaddr = 0;
        if (m_rdy) begin
            for (int i = 0; i < DEPTH; i++) m_rd[i] = m_wr[i];
            m_has = 1'b1;
            m_rdy = 1'b0;
        end
        tick();
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.rd_en = 1'b1;
            exp_q.push_back(m_has ? m_rd[m_rdaddr] : 8'h00);
            cyc_q.push_back(cyc + 1);
            m_rdaddr = (m_rdaddr + 1) % DEPTH;
            tick();
        end
        bus.rd_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic pulse_clr();
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
    endtask

    initial begin
        bus.pi_flag = 1'b0; bus.rgb = '0; bus.area2 = 1'b0;
        bus.rd_en = 1'b0; bus.area = 1'b0; bus.clr_err = 1'b0;
        m_rdy = 1'b0; m_has = 1'b0; m_rdaddr = 0;
        repeat (3) tick();
        check("rst_frame_rdy", bus.frame_rdy, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_udf", bus.udf, 0);
        check("rst_dout_vld", bus.dout_vld, 0);
        check("rst_dout", bus.dout, 0);
        rst_n = 1'b1;
        tick();

        // 1: reads with no frame ever written
        area_rise();
        read_n(4);
        check("t1_udf", bus.udf, 1);
        check("t1_frame_rdy", bus.frame_rdy, 0);
        pulse_clr();
        check("t1_udf_clr", bus.udf, 0);
        bus.area = 1'b0;
        tick();

        // 2: full frame, swap, ordered readback
        write_frame(DEPTH, 8'h00);
        check("t2_frame_rdy", bus.frame_rdy, 1);
        bus.area2 = 1'b0;
        tick();
        area_rise();
        check("t2_frame_rdy_swap", bus.frame_rdy, 0);
        read_n(DEPTH);

        // 3: continue read window past the end, address wraps
        read_n(4);
        bus.area = 1'b0;
        tick();

        // 4: partial frame is discarded, previous frame repeats
        write_frame(10, 8'hA0);
        bus.area2 = 1'b0;
        tick();
        check("t4_frame_rdy", bus.frame_rdy, 0);
        area_rise();
        read_n(DEPTH);
        check("t4_udf", bus.udf, 0);
        bus.area = 1'b0;
        tick();

        // 5: overflow on a 17th strobe, then clear
        write_frame(DEPTH + 1, 8'h40);
        check("t5_ovf", bus.ovf, 1);
        check("t5_frame_rdy", bus.frame_rdy, 1);
`ifdef PIXEL_BUF_DROP_CNT_EN
        check("t5_drop_cnt", bus.drop_cnt, 1);
`endif
        bus.area2 = 1'b0;
        tick();
        pulse_clr();
        check("t5_ovf_clr", bus.ovf, 0);
`ifdef PIXEL_BUF_DROP_CNT_EN
        check("t5_drop_clr", bus.drop_cnt, 0);
`endif
        area_rise();
        read_n(4);
        bus.area = 1'b0;
        tick();

        // 6: async reset in the middle of a fill
        write_frame(5, 8'h70);
        #2;
        rst_n = 1'b0;
        bus.area2 = 1'b0;
        #1;
        check("t6_rst_dout", bus.dout, 0);
        check("t6_rst_vld", bus.dout_vld, 0);
        check("t6_rst_frame_rdy", bus.frame_rdy, 0);
        check("t6_rst_ovf", bus.ovf, 0);
        check("t6_rst_udf", bus.udf, 0);
        m_has = 1'b0; m_rdy = 1'b0;
        @(negedge sclk);
        rst_n = 1'b1;
        tick();
        area_rise();
        read_n(2);
        check("t6_udf", bus.udf, 1);
        bus.area = 1'b0;
        tick();

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_pingpong_buf.md
Name: pixel_pingpong_buf

Overview:
Single-clock, parametrised ping-pong pixel frame buffer for the Sobel edge-detection pipeline. A capture side writes strobed pixels into one bank while the display side reads the other. Banks swap only at read-frame start, and only when a complete frame is ready. Adds width and depth generalisation, frame repeat, address wrap-around, and overflow/underflow error flags.

Parameters:
DATA_W, 8, pixel width in bits
DEPTH, 1024, pixels per frame (words per bank); must be >= 2
BLANK_VAL, 0, value output when no frame has ever been written
(ADDR_W = $clog2(DEPTH), derived localparam, not overridable)

Ports:
sclk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
pi_flag  in  1  write strobe, one pixel per high cycle
rgb  in  DATA_W  write pixel data
area2  in  1  write window; rising edge starts a new frame
rd_en  in  1  read strobe (pixel-rate enable)
area  in  1  read window; rising edge starts a new read frame
clr_err  in  1  clears ovf, udf (and drop_cnt when enabled)
dout  out  DATA_W  read data
dout_vld  out  1  dout valid pulse
frame_rdy  out  1  write bank holds a complete, unconsumed frame
ovf  out  1  sticky: write strobe ignored because frame already full
udf  out  1  sticky: read frame started with no frame ever completed

Behaviour:
- Reset (async assert, sync release): all outputs 0; wr_bank=0, rd_bank=1, has_frame=0, writer state W_IDLE, addresses 0. Reset mid-operation aborts any partial frame.
- Edge detect: rise = sig & ~sig_q, with registered copies of area2 and area.
- Writer FSM has three states: W_IDLE, W_FILL, W_DONE.
  - Any state except W_DONE, on area2 rise: wr_addr=0, go to W_FILL.
  - In W_FILL, pi_flag&area2 writes rgb to {wr_bank,wr_addr}, then wr_addr+1. This includes the rise cycle, which writes address 0.
  - The write at wr_addr=DEPTH-1 moves to W_DONE and sets frame_rdy=1 on the next cycle.
  - In W_FILL, area2 falling before DEPTH writes discards the partial frame: go to W_IDLE, frame_rdy stays 0.
  - In W_DONE, pi_flag&area2 is ignored and sets ovf. pi_flag in W_IDLE is ignored silently.
- Swap, on area rise with frame_rdy=1: wr_bank and rd_bank toggle, frame_rdy=0, has_frame=1, writer goes to W_IDLE. An area2 rise in the same cycle is evaluated after the swap, so the writer goes to W_FILL on the new wr_bank.
- Area rise with frame_rdy=0: no swap; the previous rd_bank is repeated. If has_frame=0, udf is set.
- Read side:
  - area rise sets rd_addr=0.
  - Each rd_en&area cycle reads {rd_bank,rd_addr}, then rd_addr+1. At DEPTH-1, rd_addr wraps to 0.
  - Latency is exactly 1 cycle: dout and dout_vld are registered, and dout_vld is high for one cycle per accepted rd_en.
  - dout=BLANK_VAL when has_frame=0.
  - dout holds its last value when dout_vld=0.
- clr_err vs a set event in the same cycle: the set wins.

Optional Feature:
PIXEL_BUF_DROP_CNT_EN:
- Defined: adds output drop_cnt [15:0], a saturating count of every ignored pi_flag (W_IDLE or W_DONE). It resets to 0 and is cleared by clr_err; an increment in the same cycle as clr_err wins, giving 1.
- Undefined: the port and its logic are absent.

Decomposition:
- Package pixel_buf_pkg: writer state enum (W_IDLE/W_FILL/W_DONE), DROP_CNT_W=16.
- One sub-module, pixel_buf_dpram: simple dual-port RAM of 2*DEPTH x DATA_W, one write port, registered read port, no reset on the array.

Test Plan (DEPTH=16, DATA_W=8, BLANK_VAL=0x00):
1. Reset, then area=1 and 4 rd_en pulses with no frame -> dout=0x00 with dout_vld 1 cycle after each rd_en; udf=1; frame_rdy=0.
2. area2 window with 16 pi_flag pulses, rgb=0x00..0x0F -> frame_rdy=1 the cycle after the 16th write. Then area rise -> frame_rdy=0; 16 reads return 0x00..0x0F in order, 1-cycle latency.
3. Continue the same read window to 20 rd_en -> reads 17..20 return 0x00..0x03 (wrap).
4. New area2 window, only 10 writes of 0xA0.., then area2 falls -> frame_rdy stays 0. Next area rise -> no swap; reads repeat 0x00..0x0F; udf not newly set.
5. 17 pi_flag in one area2 window -> 17th ignored, ovf=1, drop_cnt=1 (macro defined). Pulse clr_err -> ovf=0, drop_cnt=0.
6. Assert rst_n low after 5 writes of a fill -> outputs 0 immediately (async). After release, area rise plus reads -> dout=0x00, udf=1.
